// File: rtl/sw_event_conditioner.sv
`default_nettype none
// ============================================================================
// sw_event_conditioner : debounces ride-queue switches into handshaked events
// Rev 1.0
// ============================================================================
module sw_event_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       RST_N,
    input  logic [4:0] SW,
    input  logic       EV_READY,
    output logic       EV_VALID,
    output logic [1:0] EV_CODE,
    output logic       EV_CLEAR,
    output logic       ERR_MULTI
);
    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    logic [4:0]       sync1_q, sync2_q, samp_q, stab_pat_q;
    logic [CNT_W-1:0] cnt_q;
    logic             stable_q;

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic [1:0]       code_q, code_d;
    logic             clear_q, clear_d;
    logic             err_q, err_d;
    logic             clr_held_q, clr_held_d;
    logic [1:0]       op_code;

    // stable_q/stab_pat_q are registered together so the FSM always sees the
    // pattern that actually satisfied the hold time, even if p moves that edge.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            samp_q     <= '0;
            stab_pat_q <= '0;
            cnt_q      <= '0;
            stable_q   <= 1'b0;
        end else begin
            sync1_q    <= SW;
            sync2_q    <= sync1_q;
            samp_q     <= sync2_q;
            if (sync2_q != samp_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            stable_q   <= (cnt_q == CNT_MAX);
            stab_pat_q <= samp_q;
        end
    end

    always_comb begin
        op_code = 2'b00;
        if (stab_pat_q[3]) begin
            op_code = 2'b11;
        end else if (stab_pat_q[2]) begin
            op_code = 2'b10;
        end else if (stab_pat_q[1]) begin
            op_code = 2'b01;
        end
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        code_d     = code_q;
        clear_d    = 1'b0;
        err_d      = 1'b0;
        clr_held_d = clr_held_q;
        // clr_held_q keeps a held clear switch from pulsing EV_CLEAR again
        if (stable_q && stab_pat_q[4]) begin
            state_d = WAIT_REL;
            valid_d = 1'b0;
            if (!clr_held_q) begin
                clear_d    = 1'b1;
                clr_held_d = 1'b1;
            end
        end else begin
            if (stable_q) begin
                clr_held_d = 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (stable_q && (stab_pat_q[3:0] != 4'b0000)) begin
                        if ($onehot(stab_pat_q[3:0])) begin
                            state_d = ISSUE;
                            valid_d = 1'b1;
                            code_d  = op_code;
                        end else begin
                            err_d   = 1'b1;
                            state_d = WAIT_REL;
                        end
                    end
                end
                ISSUE: begin
                    if (valid_q && EV_READY) begin
                        valid_d = 1'b0;
                        state_d = WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (stable_q && (stab_pat_q == 5'b00000)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            code_q     <= 2'b00;
            clear_q    <= 1'b0;
            err_q      <= 1'b0;
            clr_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            code_q     <= code_d;
            clear_q    <= clear_d;
            err_q      <= err_d;
            clr_held_q <= clr_held_d;
        end
    end

    assign EV_VALID  = valid_q;
    assign EV_CODE   = code_q;
    assign EV_CLEAR  = clear_q;
    assign ERR_MULTI = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sw_event_conditioner.sv
`default_nettype none
// ============================================================================
// tb_sw_event_conditioner : scoreboard bench for sw_event_conditioner
// Rev 1.0
// ============================================================================
module tb_sw_event_conditioner;
    localparam int DEB = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] sw    = 5'b00000;
    logic       ready = 1'b0;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic       ev_clear;
    logic       err_multi;

    int ecnt     = 0;
    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;

    // kind: 0 = accepted event, 1 = clear pulse, 2 = multi-switch error
    typedef struct {
        int kind;
        int code;
        int at;
    } exp_t;
    exp_t sb_q[$];

    logic       prev_valid = 1'b0;
    logic [1:0] prev_code  = 2'b00;

    sw_event_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
        .CLOCK_50  (clk),
        .RST_N     (rst_n),
        .SW        (sw),
        .EV_READY  (ready),
        .EV_VALID  (ev_valid),
        .EV_CODE   (ev_code),
        .EV_CLEAR  (ev_clear),
        .ERR_MULTI (err_multi)
    );

    always #10 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp_v, ecnt);
        end
    endtask

    task automatic observe(input int kind, input int code);
        exp_t e;
        n_out++;
        if (sb_q.size() == 0) begin
            check("spurious_out_kind", kind, -1);
        end else begin
            e = sb_q.pop_front();
            check("out_kind", kind, e.kind);
            check("out_code", code, e.code);
            check("out_edge", ecnt, e.at);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_valid && ev_valid) check("code_stable", int'(ev_code), int'(prev_code));
            if (ev_clear) check("valid_on_clear", int'(ev_valid), 0);
            if (ev_clear)                observe(1, 0);
            else if (err_multi)          observe(2, 0);
            else if (ev_valid && ready)  observe(0, int'(ev_code));
        end
        prev_valid <= ev_valid;
        prev_code  <= ev_code;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int e0;
        int e1;
        int base;

        tick(3);
        check("rst_valid", int'(ev_valid), 0);
        check("rst_code",  int'(ev_code),  0);
        check("rst_clear", int'(ev_clear), 0);
        check("rst_err",   int'(err_multi), 0);
        rst_n = 1'b1;
        tick(10);

        // single press with READY high: one-cycle event at edge 7
        ready = 1'b1;
        sw    = 5'b00010;
        e0    = ecnt + 1;
        sb_q.push_back('{kind: 0, code: 1, at: e0 + 7});
        tick(7);
        check("t1_not_yet", int'(ev_valid), 0);
        tick(1);
        check("t1_valid", int'(ev_valid), 1);
        check("t1_code",  int'(ev_code),  1);
        tick(1);
        check("t1_one_cycle", int'(ev_valid), 0);
        base = n_out;
        tick(20);
        check("t1_no_repeat", n_out - base, 0);
        sw = 5'b00000;
        tick(10);

        // back-pressure, switch released during ISSUE
        ready = 1'b0;
        sw    = 5'b01000;
        e0    = ecnt + 1;
        sb_q.push_back('{kind: 0, code: 3, at: e0 + 12});
        tick(9);
        sw = 5'b00000;
        tick(4);
        check("t2_valid_held", int'(ev_valid), 1);
        check("t2_code",       int'(ev_code),  3);
        ready = 1'b1;
        tick(1);
        check("t2_valid_done", int'(ev_valid), 0);
        tick(10);

        // bounce shorter than the debounce window
        base = n_out;
        for (int i = 0; i < 10; i++) begin
            sw = (i % 2 == 0) ? 5'b00100 : 5'b00000;
            tick(3);
        end
        sw = 5'b00000;
        tick(15);
        check("t3_bounce_quiet", n_out - base, 0);

        // two ops at once, then a held single op without release
        sw = 5'b00011;
        e0 = ecnt + 1;
        sb_q.push_back('{kind: 2, code: 0, at: e0 + 7});
        tick(8);
        check("t4_err_pulse", int'(err_multi), 1);
        check("t4_no_valid",  int'(ev_valid),  0);
        tick(1);
        check("t4_err_single", int'(err_multi), 0);
        tick(4);
        base = n_out;
        sw   = 5'b00001;
        tick(15);
        check("t4_held_quiet", n_out - base, 0);
        sw = 5'b00000;
        tick(10);
        sw = 5'b00100;
        e0 = ecnt + 1;
        sb_q.push_back('{kind: 0, code: 2, at: e0 + 7});
        tick(12);
        sw = 5'b00000;
        tick(10);

        // clear while an event is pending
        ready = 1'b0;
        sw    = 5'b00001;
        tick(10);
        check("t5_pending", int'(ev_valid), 1);
        check("t5_code",    int'(ev_code),  0);
        sw = 5'b10000;
        e1 = ecnt + 1;
        sb_q.push_back('{kind: 1, code: 0, at: e1 + 7});
        tick(7);
        check("t5_still_pending", int'(ev_valid), 1);
        tick(1);
        check("t5_clear", int'(ev_clear), 1);
        check("t5_drop",  int'(ev_valid), 0);
        tick(1);
        check("t5_clear_single", int'(ev_clear), 0);
        base = n_out;
        tick(20);
        check("t5_no_repeat", n_out - base, 0);
        sw = 5'b00000;
        tick(10);

        // asynchronous reset in the middle of ISSUE
        sw = 5'b00100;
        tick(9);
        check("t6_pending", int'(ev_valid), 1);
        check("t6_code",    int'(ev_code),  2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", int'(ev_valid),  0);
        check("t6_rst_code",  int'(ev_code),   0);
        check("t6_rst_clear", int'(ev_clear),  0);
        check("t6_rst_err",   int'(err_multi), 0);
        sw = 5'b00000;
        tick(2);
        rst_n = 1'b1;
        base  = n_out;
        tick(20);
        check("t6_quiet_after_rst", n_out - base, 0);
        check("t6_valid_after_rst", int'(ev_valid), 0);

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
